// File: rtl/ysyx_22041211_wbu_pkg.sv
// rtl/ysyx_22041211_wbu_pkg.sv - shared encodings for the write-back unit
package ysyx_22041211_wbu_pkg;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_CSR = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_COMMIT   = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        reg_write;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        err;
  } wb_out_t;

endpackage

// File: rtl/ysyx_22041211_load_ext.sv
// rtl/ysyx_22041211_load_ext.sv - byte/half select, sign/zero extension, misalignment flag
module ysyx_22041211_load_ext
  import ysyx_22041211_wbu_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // Any funct3 outside the byte/half loads behaves as LW.
  always_comb begin
    data       = rdata;
    misaligned = (addr != 2'd0);
    case (mem_op)
      F3_LB: begin
        data       = {{24{byte_sel[7]}}, byte_sel};
        misaligned = 1'b0;
      end
      F3_LBU: begin
        data       = {24'd0, byte_sel};
        misaligned = 1'b0;
      end
      F3_LH: begin
        data       = {{16{half_sel[15]}}, half_sel};
        misaligned = addr[0];
      end
      F3_LHU: begin
        data       = {16'd0, half_sel};
        misaligned = addr[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_22041211_wbu.sv
// rtl/ysyx_22041211_wbu.sv - write-back unit: source select, load wait, register-file write and commit pulse
module ysyx_22041211_wbu
  import ysyx_22041211_wbu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [4:0]            in_rd,
  input  logic                  in_reg_wen,
  input  logic [1:0]            in_wb_sel,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_csr_rdata,
  input  logic [2:0]            in_mem_op,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [4:0]            rd,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  regWrite,
  output logic                  commit_valid,
  output logic [DATA_WIDTH-1:0] commit_pc,
  output logic                  err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t          state, state_n;
  wb_out_t         out_q, out_n;
  logic [31:0]     pc_q;
  logic [4:0]      rd_q;
  logic            wen_q;
  logic [2:0]      op_q;
  logic [1:0]      addr_q;
  logic [CNT_W-1:0] cnt;

  logic        waiting, accept, is_load, timeout, misaligned;
  logic [2:0]  ext_op;
  logic [1:0]  ext_addr;
  logic [31:0] ext_data, sel_data;

  assign waiting  = (state == S_WAIT_MEM);
  assign in_ready = !waiting;
  assign accept   = in_valid && in_ready;
  assign is_load  = (in_wb_sel == WB_MEM);
  assign timeout  = waiting && !mem_rvalid && (cnt == CNT_W'(MEM_TIMEOUT - 1));

  // One extender serves both the accept-time alignment check and the later data extraction.
  assign ext_op   = waiting ? op_q   : in_mem_op;
  assign ext_addr = waiting ? addr_q : in_alu_result[1:0];

  ysyx_22041211_load_ext u_load_ext (
    .mem_op     (ext_op),
    .addr       (ext_addr),
    .rdata      (mem_rdata),
    .data       (ext_data),
    .misaligned (misaligned)
  );

  always_comb begin
    case (in_wb_sel)
      WB_PC4:  sel_data = in_pc + DATA_WIDTH'(4);
      WB_CSR:  sel_data = in_csr_rdata;
      default: sel_data = in_alu_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      out_q  <= '0;
      pc_q   <= '0;
      rd_q   <= '0;
      wen_q  <= 1'b0;
      op_q   <= '0;
      addr_q <= '0;
      cnt    <= '0;
    end else begin
      state <= state_n;
      out_q <= out_n;
      if (accept) begin
        pc_q   <= in_pc;
        rd_q   <= in_rd;
        wen_q  <= in_reg_wen;
        op_q   <= in_mem_op;
        addr_q <= in_alu_result[1:0];
        cnt    <= '0;
      end else if (waiting) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_COMMIT: begin
        if (accept) state_n = (is_load && !misaligned) ? S_WAIT_MEM : S_COMMIT;
        else        state_n = S_IDLE;
      end
      S_WAIT_MEM: begin
        if (mem_rvalid)   state_n = S_COMMIT;
        else if (timeout) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    out_n              = out_q;
    out_n.reg_write    = 1'b0;
    out_n.commit_valid = 1'b0;
    case (state)
      S_IDLE, S_COMMIT: begin
        if (accept && !is_load) begin
          out_n.rd           = in_rd;
          out_n.wdata        = sel_data;
          out_n.reg_write    = in_reg_wen && (in_rd != 5'd0);
          out_n.commit_valid = 1'b1;
          out_n.commit_pc    = in_pc;
        end else if (accept && misaligned) begin
          out_n.rd           = in_rd;
          out_n.commit_valid = 1'b1;
          out_n.commit_pc    = in_pc;
          out_n.err          = 1'b1;
        end
      end
      S_WAIT_MEM: begin
        if (mem_rvalid) begin
          out_n.rd           = rd_q;
          out_n.wdata        = ext_data;
          out_n.reg_write    = wen_q && (rd_q != 5'd0);
          out_n.commit_valid = 1'b1;
          out_n.commit_pc    = pc_q;
        end else if (timeout) begin
          out_n.err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign rd           = out_q.rd;
  assign wdata        = out_q.wdata;
  assign regWrite     = out_q.reg_write;
  assign commit_valid = out_q.commit_valid;
  assign commit_pc    = out_q.commit_pc;
  assign err          = out_q.err;

endmodule
